// File: rtl/redux_mc.sv
// Multicycle Redux core: FETCH/EXEC/MEM sequencer with req/ack instruction and data ports,
// start/halt control and a retired-instruction counter.
module redux_mc #(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [7:0]       imem_data,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             halted,
  output logic [15:0]      retired
);

  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned CW   = (WIDTH < PC_W) ? WIDTH : PC_W;

  localparam logic [3:0] OP_BRZR = 4'd0,  OP_JI  = 4'd1,  OP_LD  = 4'd2,  OP_ST   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4,  OP_NOT = 4'd5,  OP_ADD = 4'd6,  OP_SUB  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8,  OP_OR  = 4'd9,  OP_XOR = 4'd10, OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12, OP_LI  = 4'd13, OP_NOP = 4'd14, OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [WIDTH-1:0] rf_q [4];
  logic [WIDTH-1:0] rf_d [4];
  logic [15:0]      ret_q, ret_d;
  logic             imem_req_q, imem_req_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;
  logic             halted_q, halted_d;

  logic [3:0]       op;
  logic [1:0]       ra, rb;
  logic [3:0]       imm;
  logic [WIDTH-1:0] ra_val, rb_val;
  logic [SH_W-1:0]  sh;
  logic [PC_W-1:0]  pc_inc, ji_off, br_tgt;

  // Instruction field decode and operand fetch
  assign op     = ir_q[7:4];
  assign ra     = ir_q[3:2];
  assign rb     = ir_q[1:0];
  assign imm    = ir_q[3:0];
  assign ra_val = rf_q[ra];
  assign rb_val = rf_q[rb];
  assign sh     = rb_val[SH_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);
  assign ji_off = PC_W'($signed(imm));
  assign br_tgt = PC_W'(rb_val[CW-1:0]);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    rf_d         = rf_q;
    ret_d        = ret_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        ret_d   = ret_q + 16'd1;
        unique case (op)
          OP_BRZR: if (ra_val == '0) pc_d = br_tgt;
          OP_JI:   pc_d = pc_q + ji_off;
          OP_LD, OP_ST: begin
            // Retirement and PC advance are deferred to the data ack
            state_d      = S_MEM;
            pc_d         = pc_q;
            ret_d        = ret_q;
            dmem_addr_d  = rb_val;
            dmem_wdata_d = ra_val;
          end
          OP_ADDI: rf_d[0]  = rf_q[0] + WIDTH'($signed(imm));
          OP_NOT:  rf_d[ra] = ~rb_val;
          OP_ADD:  rf_d[ra] = ra_val + rb_val;
          OP_SUB:  rf_d[ra] = ra_val - rb_val;
          OP_AND:  rf_d[ra] = ra_val & rb_val;
          OP_OR:   rf_d[ra] = ra_val | rb_val;
          OP_XOR:  rf_d[ra] = ra_val ^ rb_val;
          OP_SHL:  rf_d[ra] = ra_val << sh;
          OP_SHR:  rf_d[ra] = ra_val >> sh;
          OP_LI:   rf_d[0]  = WIDTH'(imm);
          OP_HALT: begin
            state_d = S_HALTED;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == OP_LD) rf_d[ra] = dmem_rdata;
          pc_d    = pc_inc;
          ret_d   = ret_q + 16'd1;
          state_d = S_FETCH;
        end
      end
      S_HALTED: ;
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs follow the state being entered, so they are registered with it
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && (op == OP_ST);
    halted_d   = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      ret_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      rf_q         <= rf_d;
      ret_q        <= ret_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign halted     = halted_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_redux_mc.sv
// Bench for redux_mc (WIDTH=16, PC_W=8): wait-state memory models, a scoreboard of expected
// fetch/data transactions, and directed programs with hand-computed results.
module tb_redux_mc;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [7:0]    imem_data = 8'h00;
  logic          dmem_req;
  logic          dmem_we;
  logic [W-1:0]  dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic          dmem_ack = 1'b0;
  logic [W-1:0]  dmem_rdata = '0;
  logic          halted;
  logic [15:0]   retired;

  redux_mc #(.WIDTH(W), .PC_W(PW), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          len;
  } ev_t;

  ev_t  sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0]   imem [256];
  logic [W-1:0] dmem [256];
  int           iwait = 0, dwait = 0;
  bit           force_iack = 0, force_dack = 0;

  // Memory models: ack after iwait/dwait extra cycles, driven on the falling edge
  int icnt = 0, dcnt = 0;
  always @(negedge clk) begin
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (imem_req) begin
      if (icnt == iwait) begin
        imem_ack  = 1'b1;
        imem_data = imem[imem_addr];
        icnt      = 0;
      end else icnt++;
    end else icnt = 0;
    if (force_iack) begin
      imem_ack  = 1'b1;
      imem_data = 8'hD3;
    end
    if (dmem_req) begin
      if (dcnt == dwait) begin
        dmem_ack = 1'b1;
        if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
        else dmem_rdata = dmem[dmem_addr[7:0]];
        dcnt = 0;
      end else dcnt++;
    end else dcnt = 0;
    if (force_dack) begin
      dmem_ack   = 1'b1;
      dmem_rdata = 16'hBEEF;
    end
  end

  // Monitor: pops the scoreboard on every acknowledged fetch and data transaction
  ev_t          me;
  int           dlen = 0;
  bit           stable = 1;
  logic         s_we;
  logic [W-1:0] s_addr, s_wd;
  always @(negedge clk) begin
    #1;
    if (imem_req && imem_ack) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL fetch_unexpected got addr=%h", imem_addr);
      end else begin
        me = sbq.pop_front();
        if (me.is_mem || me.addr[7:0] != imem_addr) begin
          bad++;
          $display("FAIL fetch got addr=%h exp is_mem=%0d addr=%h", imem_addr, me.is_mem, me.addr[7:0]);
        end
      end
    end
    if (dmem_req) begin
      if (dlen == 0) begin
        s_we = dmem_we; s_addr = dmem_addr; s_wd = dmem_wdata; stable = 1;
      end else if (s_we != dmem_we || s_addr != dmem_addr || s_wd != dmem_wdata) stable = 0;
      dlen++;
      if (dmem_ack) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL dmem_unexpected got we=%0d addr=%h", dmem_we, dmem_addr);
        end else begin
          me = sbq.pop_front();
          if (!me.is_mem || me.we != dmem_we || me.addr != dmem_addr || me.wdata != dmem_wdata
              || me.len != dlen || !stable) begin
            bad++;
            $display("FAIL dmem got we=%0d addr=%h wdata=%h len=%0d stable=%0d exp is_mem=%0d we=%0d addr=%h wdata=%h len=%0d",
                     dmem_we, dmem_addr, dmem_wdata, dlen, stable, me.is_mem, me.we, me.addr, me.wdata, me.len);
          end
        end
        dlen = 0;
      end
    end else begin
      dlen = 0;
      total++;
      if (dmem_we) begin
        bad++;
        $display("FAIL dmem_we_idle got we=%0d exp 0", dmem_we);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic push_f(input logic [7:0] a);
    ev_t e;
    e.is_mem = 0; e.we = 0; e.addr = 16'(a); e.wdata = '0; e.len = 0;
    sbq.push_back(e);
  endtask

  task automatic push_m(input bit we, input logic [15:0] a, input logic [15:0] d, input int len);
    ev_t e;
    e.is_mem = 1; e.we = we; e.addr = a; e.wdata = d; e.len = len;
    sbq.push_back(e);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_now();
  endtask

  task automatic start();
    @(posedge clk); #1; run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'h00);
    chk({tag, "_dmem_addr"}, 32'(dmem_addr), 32'h0);
    chk({tag, "_dmem_wdata"}, 32'(dmem_wdata), 32'h0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
  endtask

  task automatic load_clear();
    for (int i = 0; i < 256; i++) imem[i] = 8'hF0;
  endtask

  task automatic spurious(input int cycles);
    force_iack = 1; force_dack = 1;
    repeat (cycles) begin @(posedge clk); #1; end
    force_iack = 0; force_dack = 0;
  endtask

  initial begin
    int n;
    load_clear();
    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // Reset values and spurious acks in IDLE
    do_reset();
    chk_reset_outputs("rst");
    spurious(3);
    chk("idle_spur_retired", 32'(retired), 32'd0);
    chk("idle_spur_imem_req", 32'(imem_req), 32'd0);
    chk("idle_spur_halted", 32'(halted), 32'd0);

    // li 5; addi -1; halt: 7 cycles from first imem_req to halted
    imem[0] = 8'hD5; imem[1] = 8'h4F; imem[2] = 8'hF0;
    push_f(8'h00); push_f(8'h01); push_f(8'h02);
    start();
    chk("a_first_req", 32'(imem_req), 32'd1);
    wait_halt(n);
    chk("a_cycles", 32'(n + 1), 32'd7);
    chk("a_halted", 32'(halted), 32'd1);
    chk("a_retired", 32'(retired), 32'd3);
    spurious(3);
    repeat (2) begin @(posedge clk); #1; end
    chk("halt_spur_retired", 32'(retired), 32'd3);
    chk("halt_spur_halted", 32'(halted), 32'd1);
    chk("halt_spur_imem_req", 32'(imem_req), 32'd0);
    chk("a_sb_empty", 32'(sbq.size()), 32'd0);

    // li 5; addi -1; st R0,R1 exposes R0 = 4
    do_reset();
    load_clear();
    imem[0] = 8'hD5; imem[1] = 8'h4F; imem[2] = 8'h31; imem[3] = 8'hF0;
    push_f(8'h00); push_f(8'h01); push_f(8'h02); push_m(1'b1, 16'h0000, 16'h0004, 1); push_f(8'h03);
    start();
    wait_halt(n);
    chk("b_retired", 32'(retired), 32'd4);
    chk("b_sb_empty", 32'(sbq.size()), 32'd0);

    // li 15; add x6 -> 0x03C0; build R1 = 0x20; sub R0,R0; brzr R0,R1 -> PC 0x20
    do_reset();
    load_clear();
    imem[0] = 8'hDF;
    for (int i = 1; i <= 6; i++) imem[i] = 8'h60;
    imem[7] = 8'h31; imem[8] = 8'hD8; imem[9] = 8'h60; imem[10] = 8'h60;
    imem[11] = 8'h94; imem[12] = 8'h70; imem[13] = 8'h01;
    imem[8'h20] = 8'h31; imem[8'h21] = 8'hF0;
    for (int i = 0; i <= 7; i++) push_f(8'(i));
    push_m(1'b1, 16'h0000, 16'h03C0, 1);
    for (int i = 8; i <= 13; i++) push_f(8'(i));
    push_f(8'h20); push_m(1'b1, 16'h0020, 16'h0000, 1); push_f(8'h21);
    start();
    wait_halt(n);
    chk("c_halted", 32'(halted), 32'd1);
    chk("c_retired", 32'(retired), 32'd16);
    chk("c_sb_empty", 32'(sbq.size()), 32'd0);

    // st/ld round trip with 3 data wait states
    do_reset();
    load_clear();
    dwait = 3;
    imem[0] = 8'hDA; imem[1] = 8'h94; imem[2] = 8'hD7; imem[3] = 8'h31;
    imem[4] = 8'h29; imem[5] = 8'h3B; imem[6] = 8'hF0;
    push_f(8'h00); push_f(8'h01); push_f(8'h02); push_f(8'h03);
    push_m(1'b1, 16'h000A, 16'h0007, 4);
    push_f(8'h04); push_m(1'b0, 16'h000A, 16'h0000, 4);
    push_f(8'h05); push_m(1'b1, 16'h0000, 16'h0007, 4);
    push_f(8'h06);
    start();
    wait_halt(n);
    chk("d_retired", 32'(retired), 32'd7);
    chk("d_sb_empty", 32'(sbq.size()), 32'd0);
    dwait = 0;

    // ji -1 at PC 0 wraps to 0xFF; nop at 0xFF wraps to 0x00
    do_reset();
    load_clear();
    imem[0] = 8'h1F; imem[255] = 8'hE0;
    push_f(8'h00); push_f(8'hFF); push_f(8'h00);
    start();
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("e_sb_empty", 32'(sbq.size()), 32'd0);
    chk("e_retired", 32'(retired), 32'd2);
    reset_now();
    chk("e_reset_pc", 32'(imem_addr), 32'h00);

    // Reset in a MEM wait state with a late dmem_ack: load must not land
    load_clear();
    dmem[0] = 16'h1234;
    dwait = 5;
    imem[0] = 8'h29;
    push_f(8'h00);
    start();
    n = 0;
    while (!dmem_req && n < 20) begin @(posedge clk); #1; n++; end
    chk("f_in_mem", 32'(dmem_req), 32'd1);
    reset_now();
    force_dack = 1;
    @(posedge clk); #1;
    force_dack = 0;
    chk_reset_outputs("f");
    dwait = 0;
    imem[0] = 8'h3B; imem[1] = 8'hF0;
    push_f(8'h00); push_m(1'b1, 16'h0000, 16'h0000, 1); push_f(8'h01);
    start();
    wait_halt(n);
    chk("f_retired", 32'(retired), 32'd2);
    chk("f_sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
